// File: rtl/reg_writeback.sv
// reg_writeback: register-file write-port master.
// Merges the ALU result stream (fixed priority, never stalls) with the
// memory-load result stream (queued in a small FIFO with backpressure) into
// one registered write per cycle. A younger ALU write cancels any queued
// load to the same register; cancelled entries still drain as bubbles.
module reg_writeback #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [AW-1:0]     alu_addr_i,
  input  logic [DW-1:0]     alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [AW-1:0]     mem_addr_i,
  input  logic [DW-1:0]     mem_data_i,
  output logic              wrv_o,
  output logic [AW-1:0]     waddr_o,
  output logic [DW-1:0]     wdata_o,
  output logic [2**AW-1:0]  pending_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO storage; live is cleared on pop so live implies occupied.
  logic [AW-1:0]    fifo_addr_q [DEPTH];
  logic [AW-1:0]    fifo_addr_d [DEPTH];
  logic [DW-1:0]    fifo_data_q [DEPTH];
  logic [DW-1:0]    fifo_data_d [DEPTH];
  logic [DEPTH-1:0] fifo_live_q;
  logic [DEPTH-1:0] fifo_live_d;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  logic             wrv_q,   wrv_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  logic             alu_wr;
  logic             mem_acc;
  logic             push;
  logic             pop;
  logic             push_live;
  logic [2**AW-1:0] pending;

  // Handshake and arbitration terms; readiness depends on state only.
  assign mem_ready_o = (count_q != FULL_CNT);
  assign alu_wr      = alu_valid_i & (alu_addr_i != '0);
  assign mem_acc     = mem_valid_i & mem_ready_o;
  assign push        = mem_acc & (mem_addr_i != '0);
  assign pop         = ~alu_wr & (count_q != '0);
  // The load is older than a same-cycle ALU write to the same register.
  assign push_live   = ~(alu_wr & (mem_addr_i == alu_addr_i));

  // Next-state: cancellation, issue select, FIFO push/pop and occupancy.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_live_d = fifo_live_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wrv_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (alu_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_addr_q[i] == alu_addr_i) begin
          fifo_live_d[i] = 1'b0;
        end
      end
      wrv_d   = 1'b1;
      waddr_d = alu_addr_i;
      wdata_d = alu_data_i;
    end else if (pop) begin
      wrv_d                 = fifo_live_q[rd_ptr_q];
      waddr_d               = fifo_addr_q[rd_ptr_q];
      wdata_d               = fifo_data_q[rd_ptr_q];
      fifo_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = rd_ptr_q + 1'b1;
    end

    // Push never lands on the head slot being popped: that needs a full FIFO.
    if (push) begin
      fifo_addr_d[wr_ptr_q] = mem_addr_i;
      fifo_data_d[wr_ptr_q] = mem_data_i;
      fifo_live_d[wr_ptr_q] = push_live;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Outstanding-load map from registered FIFO state.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live_q[i]) begin
        pending[fifo_addr_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  assign pending_o = pending;

  // State registers; reset drops all queued loads and suppresses writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_live_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrv_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_live_q <= fifo_live_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wrv_q       <= wrv_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign wrv_o   = wrv_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, checked
// against a queue-based transaction model and a register-file scoreboard.
module tb_reg_writeback;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr  = '0;
  logic [DW-1:0] alu_data  = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr  = '0;
  logic [DW-1:0] mem_data  = '0;
  logic          wrv;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [15:0]   pending;

  reg_writeback #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .wrv_o(wrv), .waddr_o(waddr), .wdata_o(wdata), .pending_o(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] model_rf [16];
  logic [DW-1:0] dut_rf   [16];
  logic          exp_wrv;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  int            total = 0;
  int            bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] p = '0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].addr] = 1'b1;
    return p;
  endfunction

  // One clock: drive inputs, advance the model, then check all outputs.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit   alu_wr, acc;
    ent_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_wr = av && (aa != 0);
    acc    = mv && (mq.size() < DEPTH);
    if (alu_wr) begin
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
      exp_wrv = 1'b1; exp_waddr = aa; exp_wdata = ad;
      model_rf[aa] = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_wrv = e.live; exp_waddr = e.addr; exp_wdata = e.data;
      if (e.live) model_rf[e.addr] = e.data;
    end else begin
      exp_wrv = 1'b0;
    end
    if (acc && ma != 0) begin
      e.addr = ma; e.data = md; e.live = !(alu_wr && ma == aa);
      mq.push_back(e);
    end
    @(posedge clk); #1;
    check_val("wrv", wrv, exp_wrv);
    check_val("waddr", waddr, exp_waddr);
    check_val("wdata", wdata, exp_wdata);
    check_val("pending", pending, model_pending());
    check_val("mem_ready", mem_ready, mq.size() != DEPTH);
    if (wrv) begin
      check_val("wr_r0", waddr == 0, 0);
      dut_rf[waddr] = wdata;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 0; mem_valid = 0; alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0;
    #1;
    check_val("rst_wrv", wrv, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_ready", mem_ready, 1);
    check_val("rst_waddr", waddr, 0);
    check_val("rst_wdata", wdata, 0);
    mq.delete();
    exp_wrv = 0; exp_waddr = 0; exp_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_wrv", wrv, 0);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      model_rf[r] = '0;
      dut_rf[r]   = '0;
    end
    exp_wrv = 0; exp_waddr = 0; exp_wdata = 0;
    do_reset();

    // T2: ALU only
    step(1, 5, 16'h1234, 0, 0, 0);
    check_val("t2_wrv", wrv, 1);
    check_val("t2_waddr", waddr, 5);
    check_val("t2_wdata", wdata, 16'h1234);
    step(1, 0, 16'hFFFF, 0, 0, 0);
    check_val("t2_r0_dropped", wrv, 0);

    // T3: load latency and ordering
    step(0, 0, 0, 1, 2, 16'hAAAA);
    check_val("t3_pend_set", pending[2], 1);
    check_val("t3_no_wr_yet", wrv, 0);
    step(0, 0, 0, 1, 2, 16'hBBBB);
    check_val("t3_first", wdata, 16'hAAAA);
    idle(1);
    check_val("t3_second", wdata, 16'hBBBB);
    check_val("t3_pend_clr", pending[2], 0);
    idle(1);
    check_val("t3_done", wrv, 0);

    // Load to R0 is accepted and discarded
    step(0, 0, 0, 1, 0, 16'h5555);
    check_val("r0_load_pend", pending, 0);
    idle(1);
    check_val("r0_load_nowr", wrv, 0);

    // T4: backpressure under continuous ALU traffic
    for (int i = 0; i < 4; i++) step(1, 1, 16'h0100 + 16'(i), 1, 4'(3 + i), 16'h7000 + 16'(3 + i));
    check_val("t4_ready_low", mem_ready, 0);
    check_val("t4_pend", pending, 16'h0078);
    step(1, 1, 16'h0199, 1, 7, 16'h7007);
    check_val("t4_still_full", mem_ready, 0);
    step(0, 0, 0, 1, 7, 16'h7007);
    check_val("t4_pop1", waddr, 3);
    check_val("t4_ready_back", mem_ready, 1);
    step(0, 0, 0, 1, 7, 16'h7007);
    idle(3);
    check_val("t4_last_addr", waddr, 7);
    check_val("t4_last_data", wdata, 16'h7007);
    idle(2);

    // T5: cancellation by younger ALU write, then same-cycle case
    step(0, 0, 0, 1, 4, 16'h0001);
    step(1, 4, 16'h0002, 0, 0, 0);
    check_val("t5_alu_wr", wdata, 16'h0002);
    check_val("t5_pend_clr", pending[4], 0);
    idle(1);
    check_val("t5_bubble", wrv, 0);
    step(1, 4, 16'h0003, 1, 4, 16'h0004);
    check_val("t5b_alu_wr", wdata, 16'h0003);
    check_val("t5b_pend", pending[4], 0);
    idle(1);
    check_val("t5b_bubble", wrv, 0);
    idle(1);

    // T1: reset mid-stream with three loads queued
    for (int i = 0; i < 3; i++) step(1, 1, 16'h0A00 + 16'(i), 1, 4'(3 + i), 16'hD000 + 16'(i));
    check_val("t1_pend_before", pending, 16'h0038);
    do_reset();
    idle(6);
    check_val("t1_no_writes", wrv, 0);

    // T6: random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 40, 4'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 99) < 60, 4'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(DEPTH + 2);
    for (int r = 0; r < 16; r++) check_val($sformatf("rf_r%0d", r), dut_rf[r], model_rf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
